// File: rtl/lcd_image_ctrl.sv
// 8x8 grayscale image processor: loads from IROM, runs 2x2-block commands, dumps to IRAM.
// Optional feature macro LCD_POINT_RESET_EN: cmd 12 returns the operation point to (4,4).
module lcd_image_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        cmd,
    input  logic              cmd_valid,
    output logic              IROM_rd,
    output logic [ADDR_W-1:0] IROM_A,
    input  logic [DATA_W-1:0] IROM_Q,
    output logic              IRAM_valid,
    output logic [ADDR_W-1:0] IRAM_A,
    output logic [DATA_W-1:0] IRAM_D,
    output logic              busy,
    output logic              done
);

    localparam int NPIX = 1 << ADDR_W;

    typedef enum logic [2:0] {S_LOAD, S_IDLE, S_EXEC, S_WRITE, S_DONE} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_img [NPIX];
    logic [2:0]        r_x;
    logic [2:0]        r_y;
    logic [3:0]        r_cmd;
    logic [ADDR_W:0]   r_wcnt;

    logic [2:0]        w_xm1;
    logic [2:0]        w_ym1;
    logic [ADDR_W-1:0] w_a_tl;
    logic [ADDR_W-1:0] w_a_tr;
    logic [ADDR_W-1:0] w_a_bl;
    logic [ADDR_W-1:0] w_a_br;
    logic [DATA_W-1:0] w_p_tl;
    logic [DATA_W-1:0] w_p_tr;
    logic [DATA_W-1:0] w_p_bl;
    logic [DATA_W-1:0] w_p_br;
    logic [DATA_W-1:0] w_max;
    logic [DATA_W-1:0] w_min;
    logic [DATA_W-1:0] w_avg;

    function automatic logic [DATA_W-1:0] max4(input logic [DATA_W-1:0] a, b, c, d);
        logic [DATA_W-1:0] m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] min4(input logic [DATA_W-1:0] a, b, c, d);
        logic [DATA_W-1:0] m;
        m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        if (d < m) m = d;
        return m;
    endfunction

    // Sum in DATA_W+2 bits, then floor-divide by 4 by dropping the two LSBs.
    function automatic logic [DATA_W-1:0] avg4(input logic [DATA_W-1:0] a, b, c, d);
        logic [DATA_W+1:0] s;
        s = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
        return s[DATA_W+1:2];
    endfunction

    // Row-major addressing on an 8x8 grid is simply {row, col}.
    assign w_xm1  = r_x - 3'd1;
    assign w_ym1  = r_y - 3'd1;
    assign w_a_tl = {w_ym1, w_xm1};
    assign w_a_tr = {w_ym1, r_x};
    assign w_a_bl = {r_y, w_xm1};
    assign w_a_br = {r_y, r_x};
    assign w_p_tl = r_img[w_a_tl];
    assign w_p_tr = r_img[w_a_tr];
    assign w_p_bl = r_img[w_a_bl];
    assign w_p_br = r_img[w_a_br];
    assign w_max  = max4(w_p_tl, w_p_tr, w_p_bl, w_p_br);
    assign w_min  = min4(w_p_tl, w_p_tr, w_p_bl, w_p_br);
    assign w_avg  = avg4(w_p_tl, w_p_tr, w_p_bl, w_p_br);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_LOAD;
            busy       <= 1'b1;
            done       <= 1'b0;
            IROM_rd    <= 1'b0;
            IROM_A     <= '0;
            IRAM_valid <= 1'b0;
            IRAM_A     <= '0;
            IRAM_D     <= '0;
            r_x        <= 3'd4;
            r_y        <= 3'd4;
            r_cmd      <= 4'd0;
            r_wcnt     <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    // First cycle only presents address 0; each later edge captures one word.
                    if (!IROM_rd) begin
                        IROM_rd <= 1'b1;
                    end else if (IROM_A == '1) begin
                        IROM_rd <= 1'b0;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        IROM_A <= IROM_A + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_cmd   <= cmd;
                        busy    <= 1'b1;
                        r_wcnt  <= '0;
                        r_state <= (cmd == 4'd0) ? S_WRITE : S_EXEC;
                    end
                end
                S_EXEC: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                    case (r_cmd)
                        4'd1: if (r_y > 3'd1) r_y <= r_y - 3'd1;
                        4'd2: if (r_y < 3'd7) r_y <= r_y + 3'd1;
                        4'd3: if (r_x > 3'd1) r_x <= r_x - 3'd1;
                        4'd4: if (r_x < 3'd7) r_x <= r_x + 3'd1;
`ifdef LCD_POINT_RESET_EN
                        4'd12: begin
                            r_x <= 3'd4;
                            r_y <= 3'd4;
                        end
`endif
                        default: ;
                    endcase
                end
                S_WRITE: begin
                    if (r_wcnt[ADDR_W]) begin
                        IRAM_valid <= 1'b0;
                        done       <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        IRAM_valid <= 1'b1;
                        IRAM_A     <= r_wcnt[ADDR_W-1:0];
                        IRAM_D     <= r_img[r_wcnt[ADDR_W-1:0]];
                        r_wcnt     <= r_wcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Image buffer carries no reset; it is fully rewritten by every LOAD.
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD && IROM_rd) begin
            r_img[IROM_A] <= IROM_Q;
        end else if (r_state == S_EXEC) begin
            case (r_cmd)
                4'd5: begin
                    r_img[w_a_tl] <= w_max;
                    r_img[w_a_tr] <= w_max;
                    r_img[w_a_bl] <= w_max;
                    r_img[w_a_br] <= w_max;
                end
                4'd6: begin
                    r_img[w_a_tl] <= w_min;
                    r_img[w_a_tr] <= w_min;
                    r_img[w_a_bl] <= w_min;
                    r_img[w_a_br] <= w_min;
                end
                4'd7: begin
                    r_img[w_a_tl] <= w_avg;
                    r_img[w_a_tr] <= w_avg;
                    r_img[w_a_bl] <= w_avg;
                    r_img[w_a_br] <= w_avg;
                end
                4'd8: begin
                    r_img[w_a_tl] <= w_p_tr;
                    r_img[w_a_tr] <= w_p_br;
                    r_img[w_a_br] <= w_p_bl;
                    r_img[w_a_bl] <= w_p_tl;
                end
                4'd9: begin
                    r_img[w_a_tl] <= w_p_bl;
                    r_img[w_a_bl] <= w_p_br;
                    r_img[w_a_br] <= w_p_tr;
                    r_img[w_a_tr] <= w_p_tl;
                end
                4'd10: begin
                    r_img[w_a_tl] <= w_p_bl;
                    r_img[w_a_bl] <= w_p_tl;
                    r_img[w_a_tr] <= w_p_br;
                    r_img[w_a_br] <= w_p_tr;
                end
                4'd11: begin
                    r_img[w_a_tl] <= w_p_tr;
                    r_img[w_a_tr] <= w_p_tl;
                    r_img[w_a_bl] <= w_p_br;
                    r_img[w_a_br] <= w_p_bl;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_image_ctrl.sv
// Directed bench for lcd_image_ctrl with behavioural IROM/IRAM models.
module tb_lcd_image_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] cmd = 4'd0;
    logic       cmd_valid = 1'b0;
    logic       IROM_rd;
    logic [5:0] IROM_A;
    logic [7:0] IROM_Q = 8'd0;
    logic       IRAM_valid;
    logic [5:0] IRAM_A;
    logic [7:0] IRAM_D;
    logic       busy;
    logic       done;

    logic [7:0] rom  [64];
    logic [7:0] ram  [64];
    logic [7:0] gimg [64];
    int gx, gy;
    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    int seq [46] = '{5,1,1,3,9, 2,4,4,7,8, 1,3,3,10,11, 6,2,2,2,2, 4,4,4,4,5,
                     12,9,13,8,1, 1,1,1,1,1, 7,3,3,3,3, 3,3,10,14,15, 0};

    lcd_image_ctrl dut (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
        .IROM_rd(IROM_rd), .IROM_A(IROM_A), .IROM_Q(IROM_Q),
        .IRAM_valid(IRAM_valid), .IRAM_A(IRAM_A), .IRAM_D(IRAM_D),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (IROM_rd) IROM_Q <= rom[IROM_A];
    always @(negedge clk) if (IRAM_valid) ram[IRAM_A] <= IRAM_D;
    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reset pulse and full reload; optionally hold a Right command strobe throughout.
    task automatic reset_and_load(input bit hold_cmd);
        int n;
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("rst_busy", {31'b0, busy}, 1);
        check("rst_irom_rd", {31'b0, IROM_rd}, 0);
        check("rst_iram_valid", {31'b0, IRAM_valid}, 0);
        if (hold_cmd) begin
            cmd = 4'd4;
            cmd_valid = 1'b1;
        end
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0;
        check("load_busy_cycles_ge64", {31'b0, (n >= 64)}, 1);
        check("load_finished", {31'b0, busy}, 0);
        check("irom_rd_after_load", {31'b0, IROM_rd}, 0);
        for (int k = 0; k < 64; k++) gimg[k] = rom[k];
        gx = 4;
        gy = 4;
    endtask

    task automatic send_cmd(input logic [3:0] c);
        int n;
        @(negedge clk);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_before_cmd", {31'b0, busy}, 0);
        cmd = c;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("busy_after_accept", {31'b0, busy}, 1);
        if (c != 4'd0) begin
            @(posedge clk);
            #1;
            check("exec_one_cycle", {31'b0, busy}, 0);
        end else begin
            n = 0;
            while (busy && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("write_completes", {31'b0, busy}, 0);
        end
    endtask

    task automatic model_cmd(input int c);
        int tl, tr, bl, br, s;
        logic [7:0] a, b, d, e, m;
        tl = (gy - 1) * 8 + (gx - 1);
        tr = tl + 1;
        bl = tl + 8;
        br = tl + 9;
        a = gimg[tl]; b = gimg[tr]; d = gimg[bl]; e = gimg[br];
        case (c)
            1: if (gy > 1) gy--;
            2: if (gy < 7) gy++;
            3: if (gx > 1) gx--;
            4: if (gx < 7) gx++;
            5, 6, 7: begin
                if (c == 7) begin
                    s = a + b + d + e;
                    m = 8'(s / 4);
                end else begin
                    m = a;
                    if ((c == 5) ? (b > m) : (b < m)) m = b;
                    if ((c == 5) ? (d > m) : (d < m)) m = d;
                    if ((c == 5) ? (e > m) : (e < m)) m = e;
                end
                gimg[tl] = m; gimg[tr] = m; gimg[bl] = m; gimg[br] = m;
            end
            8:  begin gimg[tl] = b; gimg[tr] = e; gimg[br] = d; gimg[bl] = a; end
            9:  begin gimg[tl] = d; gimg[bl] = e; gimg[br] = b; gimg[tr] = a; end
            10: begin gimg[tl] = d; gimg[bl] = a; gimg[tr] = e; gimg[br] = b; end
            11: begin gimg[tl] = b; gimg[tr] = a; gimg[bl] = e; gimg[br] = d; end
`ifdef LCD_POINT_RESET_EN
            12: begin gx = 4; gy = 4; end
`endif
            default: ;
        endcase
    endtask

    task automatic write_and_compare(input string name);
        int d0;
        for (int k = 0; k < 64; k++) ram[k] = 8'hxx;
        d0 = done_cnt;
        send_cmd(4'd0);
        check({name, "_done_once"}, done_cnt - d0, 1);
        for (int k = 0; k < 64; k++)
            check($sformatf("%s_px%0d", name, k), {24'b0, ram[k]}, {24'b0, gimg[k]});
    endtask

    initial begin
        // Test 1: ROM holds its own address; immediate Write after reset.
        for (int k = 0; k < 64; k++) rom[k] = 8'(k);
        #12;
        check("rst_done", {31'b0, done}, 0);
        check("rst_iram_a", {26'b0, IRAM_A}, 0);
        check("rst_iram_d", {24'b0, IRAM_D}, 0);
        check("rst_irom_a", {26'b0, IROM_A}, 0);
        reset_and_load(1'b0);
        check("no_done_before_write", done_cnt, 0);
        write_and_compare("t1");

        // Abort a Write with reset mid-dump.
        send_cmd(4'd5);
        @(negedge clk);
        cmd = 4'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_iram_valid", {31'b0, IRAM_valid}, 0);
        check("abort_busy", {31'b0, busy}, 1);

        // Test 2: Max at (4,4) on {1,2,3,4}; Right held during load must be ignored.
        rom[27] = 8'd1; rom[28] = 8'd2; rom[35] = 8'd3; rom[36] = 8'd4;
        reset_and_load(1'b1);
        send_cmd(4'd5);
        gimg[27] = 8'd4; gimg[28] = 8'd4; gimg[35] = 8'd4; gimg[36] = 8'd4;
        write_and_compare("t2_max");

        // CW rotate on {1,2,3,4}.
        reset_and_load(1'b0);
        send_cmd(4'd9);
        gimg[27] = 8'd3; gimg[28] = 8'd1; gimg[35] = 8'd4; gimg[36] = 8'd2;
        write_and_compare("t2_cw");

        // Test 3: Avg of {10,20,30,41} = floor(101/4) = 25.
        rom[27] = 8'd10; rom[28] = 8'd20; rom[35] = 8'd30; rom[36] = 8'd41;
        reset_and_load(1'b0);
        send_cmd(4'd7);
        gimg[27] = 8'd25; gimg[28] = 8'd25; gimg[35] = 8'd25; gimg[36] = 8'd25;
        write_and_compare("t3_avg");

        // Test 4: clamp at (1,1), Mirror Y, then clamp at (7,7) and Max.
        for (int k = 0; k < 64; k++) rom[k] = 8'(k);
        reset_and_load(1'b0);
        repeat (5) send_cmd(4'd1);
        repeat (5) send_cmd(4'd3);
        send_cmd(4'd11);
        repeat (7) send_cmd(4'd2);
        repeat (7) send_cmd(4'd4);
        send_cmd(4'd5);
        gimg[0] = 8'd1; gimg[1] = 8'd0; gimg[8] = 8'd9; gimg[9] = 8'd8;
        gimg[54] = 8'd63; gimg[55] = 8'd63; gimg[62] = 8'd63;
        write_and_compare("t4_clamp");

        // Test 5: 46-command sequence against the bench model.
        for (int k = 0; k < 64; k++) rom[k] = 8'((k * 37 + 11) % 256);
        reset_and_load(1'b0);
        for (int i = 0; i < 45; i++) begin
            send_cmd(4'(seq[i]));
            model_cmd(seq[i]);
        end
        write_and_compare("t5_seq");

        // Test 6: 2x Right, cmd 12, Max.
        for (int k = 0; k < 64; k++) rom[k] = 8'(k);
        reset_and_load(1'b0);
        send_cmd(4'd4); model_cmd(4);
        send_cmd(4'd4); model_cmd(4);
        send_cmd(4'd12); model_cmd(12);
        send_cmd(4'd5); model_cmd(5);
`ifdef LCD_POINT_RESET_EN
        check("t6_model_px27", {24'b0, gimg[27]}, 36);
`else
        check("t6_model_px29", {24'b0, gimg[29]}, 38);
`endif
        write_and_compare("t6_ptreset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
